des_key_schedule: RTL and testbench
===================================

# des_key_schedule

Sequential DES round-key generator: loads a 64-bit key, applies PC-1, then steps the 56-bit C/D register through 16 rounds. Each round emits one PC-2 compressed 48-bit subkey on a valid/ready stream. It sits directly upstream of the round datapath and supplies K1..K16 in encrypt order, or K16..K1 in decrypt order. It owns the per-round rotate/compress step, so the round engine only consumes subkeys.

## Interface
- `ALLOW_RESTART`, default 0. 1 = `start` while busy aborts the current schedule and reloads; 0 = `start` while busy is ignored.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: load `key` and begin a schedule (one-cycle sample).
- `decrypt` in 1: sampled with `start`; 1 = emit subkeys in reverse order.
- `key` in 64: DES key, DES bit 1 = `key[63]`; parity bits (8,16,...,64) ignored.
- `k_valid` out 1: `k_out` holds a subkey.
- `k_ready` in 1: downstream accepts the subkey when `k_valid && k_ready`.
- `k_out` out 48: subkey, DES bit 1 = `k_out[47]`.
- `k_round` out 4: 0..15 = position in the emitted sequence (round 1..16).
- `k_last` out 1: `k_valid && k_round==15`.
- `busy` out 1: schedule in progress.
- `done` out 1: one-cycle pulse after the 16th handshake.

## Operation
- Bit numbering: a DES bit n (1-based, MSB first) in a W-bit vector sits at index W-n. Halves: C = `cd[55:28]`, D = `cd[27:0]`.
- PC-1 and PC-2 use the FIPS 46-3 tables exactly. Both C and D rotate left or right; rotates are circular and never use a logical shift.
- Encrypt schedule: round r applies rotate-left of s(r) to CD, where s(r)=1 for r in {1,2,9,16}, else 2. Subkey = PC2(CD) after the rotate.
- Decrypt schedule: round 1 applies no rotate, because CD16 = CD0. Round r≥2 applies rotate-right of 1 for r in {2,9,16}, else 2.
- State machine:
  - IDLE: `busy`=0, `k_valid`=0. On `start`, register CD = rot(PC1(key), first-round amount) and `k_out` = PC2 of that value; set `k_round`=0 and go to RUN.
  - RUN: `k_valid`=1, `busy`=1. On handshake with `k_round`<15, register CD = rot(CD, amount for round `k_round`+2), set `k_out` = PC2(new CD) and increment `k_round`.
  - RUN, 16th handshake (`k_round`==15): go to IDLE, pulse `done` for one cycle, clear `k_valid`.
- Stall: while `k_valid && !k_ready`, CD, `k_out` and `k_round` hold exactly.
- `start` during RUN:
  - `ALLOW_RESTART`=0: ignored; `decrypt` and `key` are not sampled.
  - `ALLOW_RESTART`=1: reload exactly as from IDLE, overriding any same-cycle handshake advance. No `done` pulse is issued for the aborted schedule.
- `start` in the same cycle as `done` is asserted: accepted, since the block is in IDLE.
- `decrypt` is latched at `start`; changing it mid-schedule has no effect.

## Timing
- Reset values: `k_valid`=0, `k_out`=0, `k_round`=0, `k_last`=0, `busy`=0, `done`=0, CD=0, state IDLE. Reset takes effect immediately and asynchronously, including mid-schedule; the partial schedule is discarded.
- Latency: `start` at edge N gives `k_valid`=1 with the first subkey after edge N.
- Throughput: 1 subkey/cycle with `k_ready` held high. 16 subkeys occupy 16 consecutive cycles; `done` is high in the cycle after the last handshake.
- `k_out` and `k_round` are registered. `k_last` is combinational from registered state only.
- No combinational path from `k_ready` to `k_valid` or `k_out`.

## Test plan
- Encrypt: `key`=133457799BBCDFF1, `decrypt`=0, `k_ready`=1 → K1 = 1B02EFFC7072 one cycle after `start`, K2 = 79AED9DBC9E5, K16 = CB3D8B0E17F5 with `k_last`=1; `done` pulses on the next cycle.
- Decrypt, same key → first subkey CB3D8B0E17F5, second = encrypt K15, last = 1B02EFFC7072. Check that all 16 subkeys equal the encrypt sequence reversed.
- Backpressure: `k_ready` toggled with a random pattern → `k_out`/`k_round` stable while stalled. Exactly 16 handshakes occur, the sequence is identical to the unstalled run, and there is one `done`.
- Parity insensitivity: flip every parity bit of 133457799BBCDFF1 → identical 16 subkeys.
- Mid-schedule events:
  - `start` at `k_round`=5 with `ALLOW_RESTART`=0 → ignored and the schedule continues.
  - Same with `ALLOW_RESTART`=1 → `k_round`=0 and the new K1 appear on the next cycle, with no `done` for the aborted run.
- Reset: assert `rst_n`=0 at `k_round`=9 → all outputs are 0 immediately. After release, IDLE until `start`, then a clean K1.

Source files
------------

// File: rtl/des_key_schedule.sv
// DES round-key generator: PC-1 load, per-round C/D rotate, PC-2 compress,
// one 48-bit subkey per valid/ready handshake in encrypt or decrypt order.
module des_key_schedule #(
  parameter bit ALLOW_RESTART = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        decrypt,
  input  logic [63:0] key,
  output logic        k_valid,
  input  logic        k_ready,
  output logic [47:0] k_out,
  output logic [3:0]  k_round,
  output logic        k_last,
  output logic        busy,
  output logic        done
);

  typedef enum logic {IDLE, RUN} state_t;

  // Table entries are 1-based DES bit numbers, MSB first.
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  function automatic logic [55:0] pc1_permute(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[6'(55 - i)] = k[6'(64 - PC1[i])];
    return r;
  endfunction

  function automatic logic [47:0] pc2_compress(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[6'(47 - i)] = cd[6'(56 - PC2[i])];
    return r;
  endfunction

  // Circular rotate of one 28-bit half; amount 0 passes the half through.
  function automatic logic [27:0] rot28(input logic [27:0] h, input logic right,
                                        input logic [1:0] amt);
    logic [27:0] r;
    case ({right, amt})
      3'b0_01: r = {h[26:0], h[27]};
      3'b0_10: r = {h[25:0], h[27:26]};
      3'b1_01: r = {h[0], h[27:1]};
      3'b1_10: r = {h[1:0], h[27:2]};
      default: r = h;
    endcase
    return r;
  endfunction

  // ri is the 0-based position in the emitted sequence. Decrypt position 0
  // reuses CD0 unrotated because CD16 equals CD0.
  function automatic logic [55:0] step_cd(input logic [55:0] cd, input logic dec,
                                          input logic [3:0] ri);
    logic       single;
    logic [1:0] amt;
    single = (ri == 4'd0) || (ri == 4'd1) || (ri == 4'd8) || (ri == 4'd15);
    amt    = single ? 2'd1 : 2'd2;
    if (dec && (ri == 4'd0)) amt = 2'd0;
    return {rot28(cd[55:28], dec, amt), rot28(cd[27:0], dec, amt)};
  endfunction

  state_t      state_q, state_d;
  logic [55:0] cd_q, cd_d;
  logic        dec_q, dec_d;
  logic [47:0] k_out_d;
  logic [3:0]  round_d;
  logic        done_d;
  logic        load;

  // Parity bits never reach the schedule.
  logic parity_unused;
  assign parity_unused = ^{key[56], key[48], key[40], key[32],
                           key[24], key[16], key[8], key[0]};

  // NOTE: every signal assigned below gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    dec_d   = dec_q;
    k_out_d = k_out;
    round_d = k_round;
    done_d  = 1'b0;
    load    = start && ((state_q == IDLE) || ALLOW_RESTART);

    if (load) begin
      cd_d    = step_cd(pc1_permute(key), decrypt, 4'd0);
      k_out_d = pc2_compress(cd_d);
      round_d = 4'd0;
      dec_d   = decrypt;
      state_d = RUN;
    end else if ((state_q == RUN) && k_ready) begin
      if (k_round == 4'd15) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        cd_d    = step_cd(cd_q, dec_q, k_round + 4'd1);
        k_out_d = pc2_compress(cd_d);
        round_d = k_round + 4'd1;
      end
    end
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cd_q    <= '0;
      dec_q   <= 1'b0;
      k_out   <= '0;
      k_round <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      dec_q   <= dec_d;
      k_out   <= k_out_d;
      k_round <= round_d;
      done    <= done_d;
    end
  end

  assign k_valid = (state_q == RUN);
  assign busy    = (state_q == RUN);
  assign k_last  = k_valid && (k_round == 4'd15);

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench: two instances (restart disabled/enabled) driven in
// lockstep, each with a scoreboard queue filled from an independent DES model.
module tb_des_key_schedule;

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_P = 64'h133457799BBCDFF1 ^ 64'h0101010101010101;
  localparam logic [63:0] KEY_B = 64'h0E329232EA6D0D73;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  typedef struct {
    logic [47:0] k;
    logic [3:0]  rnd;
  } exp_t;

  logic        clk, rst_n, start, decrypt, k_ready;
  logic [63:0] key;
  logic        k_valid [2];
  logic        k_last  [2];
  logic        busy    [2];
  logic        done    [2];
  logic [47:0] k_out   [2];
  logic [3:0]  k_round [2];

  des_key_schedule #(.ALLOW_RESTART(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .decrypt(decrypt), .key(key),
    .k_valid(k_valid[0]), .k_ready(k_ready), .k_out(k_out[0]),
    .k_round(k_round[0]), .k_last(k_last[0]), .busy(busy[0]), .done(done[0])
  );

  des_key_schedule #(.ALLOW_RESTART(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .decrypt(decrypt), .key(key),
    .k_valid(k_valid[1]), .k_ready(k_ready), .k_out(k_out[1]),
    .k_round(k_round[1]), .k_last(k_last[1]), .busy(busy[1]), .done(done[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  exp_t q0 [$];
  exp_t q1 [$];
  int   hs_cnt   [2];
  int   done_cnt [2];
  bit   exp_done [2];
  bit   stalled  [2];
  logic [47:0] prev_out [2];
  logic [3:0]  prev_rnd [2];
  bit   chk_stall  = 1'b0;
  bit   rand_ready = 1'b0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Reference schedule written in DES bit numbering (ascending ranges).
  function automatic logic [47:0] model_subkey(input logic [63:0] k, input int r);
    logic [1:56] cd;
    logic [1:28] c, d;
    logic [1:48] sk;
    for (int i = 1; i <= 56; i++) cd[6'(i)] = k[6'(64 - PC1_T[i-1])];
    c = cd[1:28];
    d = cd[29:56];
    for (int j = 1; j <= r; j++)
      for (int s = 0; s < SHIFTS[j-1]; s++) begin
        c = {c[2:28], c[1]};
        d = {d[2:28], d[1]};
      end
    cd = {c, d};
    for (int i = 1; i <= 48; i++) sk[6'(i)] = cd[6'(PC2_T[i-1])];
    return sk;
  endfunction

  task automatic push_run(input int u, input logic [63:0] k, input bit dec);
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      e.k   = model_subkey(k, dec ? 16 - i : i + 1);
      e.rnd = 4'(i);
      if (u == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the sampling edge.
  task automatic start_run(input logic [63:0] k_drive, input logic [63:0] k_model,
                           input bit dec);
    start   = 1'b1;
    key     = k_drive;
    decrypt = dec;
    push_run(0, k_model, dec);
    push_run(1, k_model, dec);
    @(posedge clk); #1;
    start   = 1'b0;
    decrypt = ~dec;
    key     = ~k_drive;
  endtask

  task automatic clear_counts();
    for (int u = 0; u < 2; u++) begin
      hs_cnt[u]   = 0;
      done_cnt[u] = 0;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy[0] || busy[1]) && n < 400) begin
      @(posedge clk); #1;
      if (rand_ready) k_ready = 1'($urandom_range(0, 1));
      n++;
    end
    check({tag, " idle_timeout"}, 64'(busy[0] | busy[1]), 64'd0);
    k_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic end_test(input string tag, input int hs0, input int hs1);
    check({tag, " q0_left"}, 64'(q0.size()), 64'd0);
    check({tag, " q1_left"}, 64'(q1.size()), 64'd0);
    check({tag, " hs0"}, 64'(hs_cnt[0]), 64'(hs0));
    check({tag, " hs1"}, 64'(hs_cnt[1]), 64'(hs1));
    check({tag, " done0"}, 64'(done_cnt[0]), 64'd1);
    check({tag, " done1"}, 64'(done_cnt[1]), 64'd1);
  endtask

  // Output monitor: scoreboard pops, done timing, stall stability.
  initial begin
    exp_t e;
    bit   have;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int u = 0; u < 2; u++) begin
          exp_done[u] = 1'b0;
          stalled[u]  = 1'b0;
        end
      end else begin
        for (int u = 0; u < 2; u++) begin
          if (done[u] || exp_done[u])
            check($sformatf("done_pulse u%0d", u), 64'(done[u]), 64'(exp_done[u]));
          if (done[u]) done_cnt[u]++;
          exp_done[u] = 1'b0;

          if (chk_stall && stalled[u]) begin
            check($sformatf("stall_valid u%0d", u), 64'(k_valid[u]), 64'd1);
            check($sformatf("stall_kout u%0d", u), 64'(k_out[u]), 64'(prev_out[u]));
            check($sformatf("stall_round u%0d", u), 64'(k_round[u]), 64'(prev_rnd[u]));
          end
          stalled[u]  = k_valid[u] && !k_ready;
          prev_out[u] = k_out[u];
          prev_rnd[u] = k_round[u];

          if (k_valid[u] && k_ready) begin
            have = 1'b0;
            if (u == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            if (u == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            hs_cnt[u]++;
            if (!have) begin
              check($sformatf("unexpected_hs u%0d", u), 64'(k_round[u]), 64'hFFFF);
            end else begin
              check($sformatf("k_out u%0d r%0d", u, e.rnd), 64'(k_out[u]), 64'(e.k));
              check($sformatf("k_round u%0d", u), 64'(k_round[u]), 64'(e.rnd));
              check($sformatf("k_last u%0d r%0d", u, e.rnd), 64'(k_last[u]),
                    64'(e.rnd == 4'd15));
              exp_done[u] = (e.rnd == 4'd15) && !(start && u == 1);
            end
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n   = 1'b0;
    start   = 1'b0;
    decrypt = 1'b0;
    k_ready = 1'b0;
    key     = '0;
    clear_counts();
    #12;
    for (int u = 0; u < 2; u++) begin
      check($sformatf("rst k_valid u%0d", u), 64'(k_valid[u]), 64'd0);
      check($sformatf("rst k_out u%0d", u), 64'(k_out[u]), 64'd0);
      check($sformatf("rst k_round u%0d", u), 64'(k_round[u]), 64'd0);
      check($sformatf("rst busy u%0d", u), 64'(busy[u]), 64'd0);
      check($sformatf("rst done u%0d", u), 64'(done[u]), 64'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Encrypt, k_ready held high: fixed known-answer subkeys and timing.
    k_ready = 1'b1;
    clear_counts();
    start_run(KEY_A, KEY_A, 1'b0);
    check("enc latency valid", 64'(k_valid[0]), 64'd1);
    check("enc K1", 64'(k_out[0]), 64'h1B02EFFC7072);
    @(posedge clk); #1;
    check("enc K2", 64'(k_out[0]), 64'h79AED9DBC9E5);
    repeat (14) begin @(posedge clk); #1; end
    check("enc K16", 64'(k_out[0]), 64'hCB3D8B0E17F5);
    check("enc last", 64'(k_last[0]), 64'd1);
    @(posedge clk); #1;
    check("enc done", 64'(done[0]), 64'd1);
    check("enc valid_off", 64'(k_valid[0]), 64'd0);
    wait_idle("enc");
    end_test("enc", 16, 16);

    // Decrypt: reversed order.
    clear_counts();
    start_run(KEY_A, KEY_A, 1'b1);
    check("dec first", 64'(k_out[0]), 64'hCB3D8B0E17F5);
    @(posedge clk); #1;
    check("dec second", 64'(k_out[0]), 64'(model_subkey(KEY_A, 15)));
    repeat (14) begin @(posedge clk); #1; end
    check("dec last", 64'(k_out[0]), 64'h1B02EFFC7072);
    wait_idle("dec");
    end_test("dec", 16, 16);

    // Random backpressure.
    clear_counts();
    chk_stall  = 1'b1;
    rand_ready = 1'b1;
    k_ready    = 1'b0;
    start_run(KEY_A, KEY_A, 1'b0);
    wait_idle("bp");
    chk_stall  = 1'b0;
    rand_ready = 1'b0;
    end_test("bp", 16, 16);

    // Parity bits flipped: same subkeys as the original key.
    clear_counts();
    start_run(KEY_P, KEY_A, 1'b0);
    wait_idle("par");
    end_test("par", 16, 16);

    // start while running at k_round 5.
    clear_counts();
    start_run(KEY_A, KEY_A, 1'b0);
    n = 0;
    while (k_round[0] != 4'd5 && n < 50) begin @(posedge clk); #1; n++; end
    check("rs reach5", 64'(k_round[0]), 64'd5);
    start   = 1'b1;
    key     = KEY_B;
    decrypt = 1'b0;
    while (q1.size() > 1) void'(q1.pop_back());
    push_run(1, KEY_B, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    check("rs u0 continues", 64'(k_round[0]), 64'd6);
    check("rs u1 round0", 64'(k_round[1]), 64'd0);
    check("rs u1 newK1", 64'(k_out[1]), 64'(model_subkey(KEY_B, 1)));
    wait_idle("rs");
    end_test("rs", 16, 22);

    // Asynchronous reset mid-schedule.
    clear_counts();
    start_run(KEY_A, KEY_A, 1'b0);
    n = 0;
    while (k_round[0] != 4'd9 && n < 50) begin @(posedge clk); #1; n++; end
    check("rst9 reach9", 64'(k_round[0]), 64'd9);
    #2 rst_n = 1'b0;
    #1;
    for (int u = 0; u < 2; u++) begin
      check($sformatf("arst k_valid u%0d", u), 64'(k_valid[u]), 64'd0);
      check($sformatf("arst k_out u%0d", u), 64'(k_out[u]), 64'd0);
      check($sformatf("arst k_round u%0d", u), 64'(k_round[u]), 64'd0);
      check($sformatf("arst k_last u%0d", u), 64'(k_last[u]), 64'd0);
      check($sformatf("arst busy u%0d", u), 64'(busy[u]), 64'd0);
    end
    q0.delete();
    q1.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("post_rst idle valid", 64'(k_valid[0]), 64'd0);
    check("post_rst idle busy", 64'(busy[1]), 64'd0);
    clear_counts();
    start_run(KEY_A, KEY_A, 1'b0);
    check("post_rst K1", 64'(k_out[0]), 64'h1B02EFFC7072);
    wait_idle("post_rst");
    end_test("post_rst", 16, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
